// File: rtl/red_pitaya_pwm_sched.sv
// rtl/red_pitaya_pwm_sched.sv - period-aligned duty/mode/divider commit sequencer with slew-limited ramps
module red_pitaya_pwm_sched #(
    parameter int N_CH = 4,
    parameter int CCW  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          sys_addr,
    input  logic [31:0]         sys_wdata,
    input  logic                sys_wen,
    input  logic                sys_ren,
    output logic [31:0]         sys_rdata,
    output logic                sys_ack,
    output logic                sys_err,
    input  logic [N_CH-1:0]     pwm_sync_i,
    output logic [N_CH*CCW-1:0] cfg_o,
    output logic [N_CH-1:0]     mode_o,
    output logic [15:0]         freq_div_o,
    output logic [N_CH-1:0]     busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RAMP  = 2'd2
    } state_t;

    localparam logic [4:0] NCH5 = 5'(N_CH);

    logic [CCW-1:0] tgt_sh_q  [N_CH];
    logic [CCW-1:0] tgt_sh_d  [N_CH];
    logic [CCW-1:0] step_sh_q [N_CH];
    logic [CCW-1:0] step_sh_d [N_CH];
    logic [CCW-1:0] tgt_a_q   [N_CH];
    logic [CCW-1:0] tgt_a_d   [N_CH];
    logic [CCW-1:0] step_a_q  [N_CH];
    logic [CCW-1:0] step_a_d  [N_CH];
    logic [CCW-1:0] cur_q     [N_CH];
    logic [CCW-1:0] cur_d     [N_CH];
    state_t         state_q   [N_CH];
    state_t         state_d   [N_CH];
    logic [N_CH-1:0] mode_sh_q, mode_sh_d;
    logic [N_CH-1:0] mode_a_q, mode_a_d;
    logic [N_CH-1:0] mode_q, mode_d;
    logic [15:0]     fd_sh_q, fd_sh_d;
    logic [15:0]     fd_q, fd_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [3:0] ch_sel;
    logic [1:0] reg_sel;
    logic       is_fd;
    logic       is_ch;
    logic       unused_ok;

    assign ch_sel    = sys_addr[7:4];
    assign reg_sel   = sys_addr[3:2];
    assign is_fd     = (sys_addr[7:2] == 6'h20);
    assign is_ch     = ({1'b0, ch_sel} < NCH5);
    assign unused_ok = ^{sys_wdata[31:24], sys_addr[1:0]};

    // One slew step toward tgt; a zero step or a gap within one step lands exactly on tgt.
    function automatic logic [CCW-1:0] step_toward(input logic [CCW-1:0] cur,
                                                   input logic [CCW-1:0] tgt,
                                                   input logic [CCW-1:0] stp);
        logic [CCW:0] diff;
        logic [CCW:0] mag;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[CCW] ? (~diff + 1'b1) : diff;
        if (stp == '0 || mag <= {1'b0, stp}) begin
            return tgt;
        end else if (diff[CCW]) begin
            return cur - stp;
        end else begin
            return cur + stp;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                tgt_sh_q[k]  <= '0;
                step_sh_q[k] <= '0;
                tgt_a_q[k]   <= '0;
                step_a_q[k]  <= '0;
                cur_q[k]     <= '0;
                state_q[k]   <= S_IDLE;
            end
            mode_sh_q <= '0;
            mode_a_q  <= '0;
            mode_q    <= '0;
            fd_sh_q   <= 16'd1;
            fd_q      <= 16'd1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                tgt_sh_q[k]  <= tgt_sh_d[k];
                step_sh_q[k] <= step_sh_d[k];
                tgt_a_q[k]   <= tgt_a_d[k];
                step_a_q[k]  <= step_a_d[k];
                cur_q[k]     <= cur_d[k];
                state_q[k]   <= state_d[k];
            end
            mode_sh_q <= mode_sh_d;
            mode_a_q  <= mode_a_d;
            mode_q    <= mode_d;
            fd_sh_q   <= fd_sh_d;
            fd_q      <= fd_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        logic wr_k, ctrl_wr, go, abort, sync;
        mode_sh_d = mode_sh_q;
        mode_a_d  = mode_a_q;
        mode_d    = mode_q;
        fd_sh_d   = fd_sh_q;
        fd_d      = pwm_sync_i[0] ? fd_sh_q : fd_q;
        if (sys_wen && is_fd) begin
            fd_sh_d = (sys_wdata[15:0] == 16'd0) ? 16'd1 : sys_wdata[15:0];
        end
        for (int k = 0; k < N_CH; k++) begin
            tgt_sh_d[k]  = tgt_sh_q[k];
            step_sh_d[k] = step_sh_q[k];
            tgt_a_d[k]   = tgt_a_q[k];
            step_a_d[k]  = step_a_q[k];
            cur_d[k]     = cur_q[k];
            state_d[k]   = state_q[k];
            wr_k    = sys_wen && is_ch && (ch_sel == 4'(k));
            ctrl_wr = wr_k && (reg_sel == 2'd2);
            abort   = ctrl_wr && sys_wdata[2];
            go      = ctrl_wr && sys_wdata[1];
            sync    = pwm_sync_i[k];
            if (wr_k && reg_sel == 2'd0) tgt_sh_d[k]  = sys_wdata[CCW-1:0];
            if (wr_k && reg_sel == 2'd1) step_sh_d[k] = sys_wdata[CCW-1:0];
            if (ctrl_wr) mode_sh_d[k] = sys_wdata[0];
            if (abort) begin
                state_d[k] = S_IDLE;
            end else begin
                // A sync coinciding with go acts on the state and targets latched before the write.
                if (sync && state_q[k] != S_IDLE) begin
                    cur_d[k]   = step_toward(cur_q[k], tgt_a_q[k], step_a_q[k]);
                    mode_d[k]  = mode_a_q[k];
                    state_d[k] = (cur_d[k] == tgt_a_q[k]) ? S_IDLE : S_RAMP;
                end
                if (go) begin
                    tgt_a_d[k]  = tgt_sh_q[k];
                    step_a_d[k] = step_sh_q[k];
                    mode_a_d[k] = sys_wdata[0];
                    if (state_q[k] == S_IDLE) begin
                        state_d[k] = S_ARMED;
                    end else if (sync) begin
                        state_d[k] = S_RAMP;
                    end
                end
            end
        end
    end

    always_comb begin
        ack_d   = sys_wen || sys_ren;
        err_d   = 1'b0;
        rdata_d = '0;
        if (sys_wen || sys_ren) begin
            if (!is_fd && !is_ch) begin
                err_d = 1'b1;
            end else if (sys_ren && is_fd) begin
                rdata_d = {16'd0, fd_sh_q};
            end else if (sys_ren) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_sel == 4'(k)) begin
                        case (reg_sel)
                            2'd0:    rdata_d = 32'(tgt_sh_q[k]);
                            2'd1:    rdata_d = 32'(step_sh_q[k]);
                            2'd2:    rdata_d = {31'd0, mode_sh_q[k]};
                            default: rdata_d = {6'd0, state_q[k], cur_q[k]};
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cfg_o[k*CCW +: CCW] = cur_q[k];
            busy_o[k]           = (state_q[k] != S_IDLE);
        end
        mode_o     = mode_q;
        freq_div_o = fd_q;
        sys_ack    = ack_q;
        sys_err    = err_q;
        sys_rdata  = rdata_q;
    end

endmodule

// File: doc/red_pitaya_pwm_sched.md
# red_pitaya_pwm_sched

Sequencer for a bank of slow-DAC PWM channels. It owns the per-channel duty-cycle word (`cfg`), the dither-mode select and the shared clock-divider word. It takes register writes from the system bus and commits them to the PWM datapath only on each channel's period boundary (`pwm_s`), so a new value never lands mid-period. It also supports slew-limited ramps toward a target, with one step applied per PWM metacycle.

## Interface
- `N_CH`, default 4: number of PWM channels; range 1..8.
- `CCW`, default 24: duty-cycle word width; fixed at 24 for the `[23:16]` coarse / `[15:0]` dither split.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `sys_addr`  in  8  byte address; bits `[1:0]` are ignored.
- `sys_wdata`  in  32  write data.
- `sys_wen`  in  1  write strobe, one cycle.
- `sys_ren`  in  1  read strobe, one cycle.
- `sys_rdata`  out  32  read data, valid when `sys_ack`=1.
- `sys_ack`  out  1  access acknowledge.
- `sys_err`  out  1  unmapped-address flag, valid with `sys_ack`.
- `pwm_sync_i`  in  N_CH  per-channel `pwm_s` from the PWM instances.
- `cfg_o`  out  N_CH*CCW  committed duty words; channel k occupies `[k*24 +: 24]`.
- `mode_o`  out  N_CH  committed mode (1 = dithered).
- `freq_div_o`  out  16  committed divider, shared by all channels.
- `busy_o`  out  N_CH  channel k is ARMED or RAMP.

## Operation
Register map. Channel k occupies `0x10*k`:
- `+0x0` TARGET[23:0], read/write.
- `+0x4` STEP[23:0], read/write.
- `+0x8` CTRL: bit0 mode, bit1 go (write-1 pulse), bit2 abort (write-1 pulse), read/write. Bits 1 and 2 read back as 0.
- `+0xC` STATUS, read-only: [23:0] current `cfg_o`; [25:24] state (0 IDLE, 1 ARMED, 2 RAMP).

Global register at `0x80`: FREQ_DIV[15:0], read/write. Writing 0 stores 1.

Address decode:
- Addresses at or above `0x10*N_CH`, other than `0x80`, are unmapped.
- Unmapped read: `sys_rdata`=0, `sys_err`=1.
- Unmapped write: discarded, `sys_err`=1.

Per-channel FSM:
- IDLE: a go write captures TARGET, STEP and mode into active registers and moves to ARMED. In IDLE, a go write with STEP=0 is still accepted and behaves as a jump.
- ARMED, on sync:
  - `mode_o` takes the latched mode.
  - If STEP=0, `cfg_o` jumps to the target; go to IDLE.
  - Otherwise apply one step; go to RAMP, or to IDLE if the target is reached.
- RAMP, on each sync: apply one step; go to IDLE when `cfg_o` equals the target.
- Step arithmetic:
  - diff = target − cur, 25-bit signed.
  - If |diff| ≤ step, cur = target.
  - Otherwise cur = cur ± step, so the result never overshoots and never wraps.
- Abort in ARMED or RAMP: go to IDLE and hold `cfg_o` at its current value; no further change.
- Go in ARMED or RAMP: re-latch the active registers from TARGET/STEP/mode and keep the current state. The ramp continues from the current `cfg_o` toward the new target.
- Writes to TARGET, STEP or mode alone never change the outputs; only go does.
- FREQ_DIV: shadowed, then copied to `freq_div_o` on the first `pwm_sync_i[0]` after the write. With `N_CH`=1 the same rule applies.

## Timing
- Reset values:
  - `cfg_o`=0, `mode_o`=0, `freq_div_o`=1, `busy_o`=0.
  - `sys_ack`=0, `sys_err`=0, `sys_rdata`=0.
  - All FSMs IDLE, all shadow registers 0, FREQ_DIV shadow = 1.
- `rst` mid-ramp: outputs take reset values on the next edge; no pending commit survives.
- Bus:
  - `sys_ack` is asserted exactly 1 cycle after `sys_wen` or `sys_ren`, for 1 cycle.
  - Back-to-back accesses on consecutive cycles are all acknowledged.
  - `sys_wen` and `sys_ren` asserted together is treated as a write plus a read of the pre-write value.
- Commit latency: `cfg_o`/`mode_o` change on the edge following the `clk` cycle in which `pwm_sync_i[k]`=1.
- `busy_o` rises the cycle after the go write and falls with the final commit.
- Same-cycle collisions:
  - Go write and sync in the same cycle: the sync acts on the pre-write state. An IDLE channel ignores the sync and arms; the new value commits on the next sync.
  - Abort and sync in the same cycle: abort wins; no step is applied.
  - Abort and go in the same write: abort wins.
- Channels are independent. Simultaneous syncs on several channels are all serviced in the same cycle.

## Test plan
- Reset, then read back everything → all registers 0, FREQ_DIV=1, `cfg_o`=0, and `sys_ack` is a 1-cycle pulse 1 cycle after each strobe.
- Channel 0: TARGET=0x123456, STEP=0, go; pulse `pwm_sync_i[0]` 20 cycles later → `cfg_o[23:0]` holds 0 until the sync, then becomes 0x123456 the next edge; `busy_o[0]` high for exactly that window.
- Channel 1: cur=0, TARGET=0x000A00, STEP=0x000300, go; 4 syncs → `cfg_o` steps 0x300, 0x600, 0x900, 0xA00, then IDLE. Repeat downward from 0xA00 to 0 → 0x700, 0x400, 0x100, 0x000.
- Ramp TARGET=0xFFFFFF, STEP=0x800000 from 0 → 0x800000, then 0xFFFFFF with no wrap; abort while ramping → `cfg_o` frozen, STATUS state=0.
- Go write coinciding with `pwm_sync_i[2]`, and abort coinciding with a sync → no commit on that sync in both cases; the collision rules above hold.
- FREQ_DIV write 0, then sync on channel 0 → `freq_div_o`=1; write 0x0010 → unchanged until the next `pwm_sync_i[0]`, then 0x0010. Access to `0x44` (with `N_CH`=4) → `sys_err`=1, rdata 0.
